// File: rtl/fp_add_special_case.sv
// ---------------------------------------------------------------------------
// fp_add_special_case
//   Special-operand classifier for the double-precision FP adder. It decodes
//   the per-operand class flags from unpack and registers three bypass flags
//   for the rounder/packer: infinite result, quiet-NaN result and the IEEE
//   invalid-operation exception.
//
// Ports
//   clk       in   1    system clock, rising edge
//   rst       in   1    synchronous, active-high reset
//   in_valid  in   1    sa/sb/fla/flb valid this cycle
//   sa, sb    in   1    sign of a, effective sign of b (subtract already folded)
//   fla, flb  in   FLW  class flags: [52]=INF [51]=QNAN [50]=SNAN [49]=ZERO
//   out_valid out  1    registered flags below are valid
//   INFs      out  1    result is +/-infinity
//   sINF      out  1    sign of the infinite result (0 when INFs=0)
//   NANs      out  1    result is a quiet NaN
//   INV       out  1    invalid-operation exception
// ---------------------------------------------------------------------------

// Per-operand priority decode: SNAN > QNAN > INF. ZERO and the reserved
// bits never reach here; zeros are resolved in the datapath.
module fp_add_class_dec (
    input  logic [2:0] cls,   // {INF, QNAN, SNAN}
    output logic       snan,
    output logic       qnan,
    output logic       inf
);
    assign snan = cls[0];
    assign qnan = cls[1] & ~cls[0];
    assign inf  = cls[2] & ~cls[1] & ~cls[0];
endmodule

module fp_add_special_case #(
    parameter int FLW = 53
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           sa,
    input  logic           sb,
    input  logic [FLW-1:0] fla,
    input  logic [FLW-1:0] flb,
    output logic           out_valid,
    output logic           INFs,
    output logic           sINF,
    output logic           NANs,
    output logic           INV
);
    localparam int NOPS   = 2;
    localparam int STAGES = 1;

    typedef struct packed {
        logic infs;
        logic sinf;
        logic nans;
        logic inv;
    } res_t;

    logic [NOPS-1:0][FLW-1:0] fl_op;
    logic [NOPS-1:0]          sgn_op;
    logic [NOPS-1:0]          s_op, q_op, i_op;
    logic [STAGES:0]          vld_pipe;
    res_t                     res_d, res_q;

    assign fl_op  = {flb, fla};
    assign sgn_op = {sb, sa};

    // ZERO and reserved bits are deliberately ignored.
    logic unused_fl_bits;
    assign unused_fl_bits = ^{fla[FLW-4:0], flb[FLW-4:0]};

    genvar g;
    generate
        for (g = 0; g < NOPS; g++) begin : g_dec
            fp_add_class_dec u_dec (
                .cls  (fl_op[g][FLW-1:FLW-3]),
                .snan (s_op[g]),
                .qnan (q_op[g]),
                .inf  (i_op[g])
            );
        end
    endgenerate

    always_comb begin
        res_d      = '0;
        // inf - inf (opposite effective signs) or any signalling NaN
        res_d.inv  = (|s_op) | (&i_op & (sgn_op[0] ^ sgn_op[1]));
        res_d.nans = res_d.inv | (|q_op);
        res_d.infs = ~res_d.nans & (|i_op);
        // a is chosen first; when both are inf here their signs agree
        res_d.sinf = res_d.infs & (i_op[0] ? sgn_op[0] : sgn_op[1]);
    end

    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            res_q              <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            // flags hold across idle cycles
            if (in_valid) res_q <= res_d;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign INFs      = res_q.infs;
    assign sINF      = res_q.sinf;
    assign NANs      = res_q.nans;
    assign INV       = res_q.inv;
endmodule

// File: tb/tb_fp_add_special_case.sv
module tb_fp_add_special_case;
    localparam int FLW = 53;
    localparam logic [FLW-1:0] F_INF  = 53'(1) << 52;
    localparam logic [FLW-1:0] F_QNAN = 53'(1) << 51;
    localparam logic [FLW-1:0] F_SNAN = 53'(1) << 50;
    localparam logic [FLW-1:0] F_ZERO = 53'(1) << 49;

    logic           clk = 1'b0;
    logic           rst, in_valid, sa, sb;
    logic [FLW-1:0] fla, flb;
    logic           out_valid, INFs, sINF, NANs, INV;

    int passed = 0;
    int total  = 0;

    // expected registered state: {INFs, sINF, NANs, INV}
    logic [3:0] exp_flags = 4'b0;
    logic       exp_ov    = 1'b0;

    fp_add_special_case #(.FLW(FLW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sa(sa), .sb(sb),
        .fla(fla), .flb(flb), .out_valid(out_valid),
        .INFs(INFs), .sINF(sINF), .NANs(NANs), .INV(INV)
    );

    always #5 clk = ~clk;

    // 4 = SNaN, 3 = QNaN, 2 = Inf, 1 = zero, 0 = finite
    function automatic int cls_of(input logic [FLW-1:0] f);
        if (f[50]) return 4;
        if (f[51]) return 3;
        if (f[52]) return 2;
        if (f[49]) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] ref_flags(input logic a_s, input logic b_s,
                                             input logic [FLW-1:0] a_f,
                                             input logic [FLW-1:0] b_f);
        int ca, cb;
        ca = cls_of(a_f);
        cb = cls_of(b_f);
        if (ca == 4 || cb == 4)                   return 4'b0011;
        if (ca == 2 && cb == 2 && a_s != b_s)     return 4'b0011;
        if (ca == 3 || cb == 3)                   return 4'b0010;
        if (ca == 2)                              return {1'b1, a_s, 2'b00};
        if (cb == 2)                              return {1'b1, b_s, 2'b00};
        return 4'b0000;
    endfunction

    function automatic logic [FLW-1:0] rnd_fl();
        logic [63:0] r;
        logic [FLW-1:0] f;
        r = {$urandom(), $urandom()};
        f = r[FLW-1:0];
        // a quarter of the time: no class bits at all
        if ($urandom_range(0, 3) == 0) f[52:49] = 4'b0000;
        return f;
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got {ov,INFs,sINF,NANs,INV}=%b expected %b", tag, got, exp);
    endtask

    // Apply one cycle of inputs, then check the registered result 1 time unit
    // after the capturing edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic a_s, input logic b_s,
                        input logic [FLW-1:0] a_f, input logic [FLW-1:0] b_f);
        rst = r; in_valid = v; sa = a_s; sb = b_s; fla = a_f; flb = b_f;
        @(posedge clk);
        #1;
        if (r) begin
            exp_flags = 4'b0;
            exp_ov    = 1'b0;
        end else begin
            exp_ov = v;
            if (v) exp_flags = ref_flags(a_s, b_s, a_f, b_f);
        end
        check(tag, {out_valid, INFs, sINF, NANs, INV}, {exp_ov, exp_flags});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sa = 1'b0; sb = 1'b0; fla = '0; flb = '0;

        // reset with random activity on the inputs
        step("reset0", 1'b1, 1'b1, 1'($urandom()), 1'($urandom()), rnd_fl(), rnd_fl());
        step("reset1", 1'b1, 1'b1, 1'($urandom()), 1'($urandom()), rnd_fl(), rnd_fl());

        // directed cases
        step("inf_plus_inf_neg", 1'b0, 1'b1, 1'b1, 1'b1, F_INF, F_INF);
        step("snan_b",           1'b0, 1'b1, 1'b1, 1'b0, F_INF | F_QNAN, F_SNAN);
        step("inf_minus_inf",    1'b0, 1'b1, 1'b0, 1'b1, F_INF, F_INF);
        step("inf_b_only",       1'b0, 1'b1, 1'b1, 1'b1, '0, F_INF);
        step("qnan_a",           1'b0, 1'b1, 1'b1, 1'b0, F_QNAN, '0);
        step("zero_a_inf_b",     1'b0, 1'b1, 1'b1, 1'b0, F_ZERO, F_INF);
        step("zero_zero",        1'b0, 1'b1, 1'b1, 1'b0, F_ZERO, F_ZERO | 53'h1_2345);
        step("snan_over_all",    1'b0, 1'b1, 1'b0, 1'b0, F_INF | F_QNAN | F_SNAN | F_ZERO, '0);

        // back-to-back stream then one idle cycle: flags hold, valid drops
        step("stream_a", 1'b0, 1'b1, 1'b1, 1'b1, F_INF, F_INF);
        step("stream_b", 1'b0, 1'b1, 1'b1, 1'b0, F_INF | F_QNAN, F_SNAN);
        step("stream_c", 1'b0, 1'b1, 1'b0, 1'b1, F_INF, F_INF);
        step("idle_hold", 1'b0, 1'b0, 1'b1, 1'b1, F_INF, '0);
        step("after_idle", 1'b0, 1'b1, 1'b0, 1'b0, '0, F_INF);

        // reset mid-stream overrides in_valid
        step("reset_mid", 1'b1, 1'b1, 1'b1, 1'b1, F_INF, F_INF);

        // randomized traffic, occasional idle and reset cycles
        for (int i = 0; i < 400; i++) begin
            logic r, v;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 4) != 0);
            step("random", r, v, 1'($urandom()), 1'($urandom()), rnd_fl(), rnd_fl());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
